// File: rtl/demux1_16_deserializer_if.sv
// Bus bundle for the 1:16 demux deserializer: serial beat input side plus parallel word output side.
// Handshakes: a beat transfers on a rising edge where bit_valid & bit_ready; a word transfers where out_valid & out_ready.
interface demux1_16_deserializer_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
);
  logic             start;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [SEL_W-1:0] s;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             parity_err;

  modport master (
    output start, bit_in, bit_valid, out_ready,
    input  bit_ready, s, out, out_valid, parity_err
  );

  modport slave (
    input  start, bit_in, bit_valid, out_ready,
    output bit_ready, s, out, out_valid, parity_err
  );
endinterface

// File: rtl/demux1_16_deserializer.sv
// Serial-to-parallel receiver: each accepted bit is steered into out[s], s auto-increments, word held until taken.
// Optional macro PARITY_CHECK_EN adds one even-parity beat after the data bits and drives parity_err.
module demux1_16_deserializer #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  demux1_16_deserializer_if.slave       bus,
  output logic [1:0]                    dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             bit_ready_q, bit_ready_d;
  logic             parity_err_q, parity_err_d;
  logic             restart;
  logic             accept;

  assign accept = bus.bit_valid & bit_ready_q;

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    out_d        = out_q;
    parity_err_d = parity_err_q;
    // In HOLD a start only counts together with the word being taken, so no word is ever dropped.
    restart      = (state_q == HOLD) ? (bus.start & bus.out_ready) : bus.start;

    if (restart) begin
      state_d      = COLLECT;
      out_d        = '0;
      s_d          = '0;
      parity_err_d = 1'b0;
      if (bus.bit_valid) begin
        out_d[0] = bus.bit_in;
        s_d      = SEL_W'(1);
      end
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            out_d[s_q] = bus.bit_in;
            s_d        = s_q + SEL_W'(1);
            if (s_q == SEL_W'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
              state_d = PARITY;
`else
              state_d = HOLD;
`endif
            end
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          if (accept) begin
            parity_err_d = (^out_q) ^ bus.bit_in;
            state_d      = HOLD;
          end
        end
`endif
        HOLD: begin
          if (bus.out_ready) begin
            state_d      = IDLE;
            parity_err_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    out_valid_d = (state_d == HOLD);
    bit_ready_d = (state_d == COLLECT) || (state_d == PARITY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_q          <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      bit_ready_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      bit_ready_q  <= bit_ready_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bit_ready = bit_ready_q;
  assign dbg_state     = state_q;
`ifdef PARITY_CHECK_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux1_16_deserializer.sv
// Directed bench for demux1_16_deserializer: frames, select sweep, HOLD stall, abort, async reset, parity.
module tb_demux1_16_deserializer;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_vec;
  int         n_err;

  demux1_16_deserializer_if #(.WIDTH(16), .SEL_W(4)) bus ();

  demux1_16_deserializer #(.WIDTH(16), .SEL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic b);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    tick();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) beat(w[i]);
  endtask

  task automatic send_parity(input logic p);
`ifdef PARITY_CHECK_EN
    beat(p);
`else
    if (p === 1'bx) tick();
`endif
  endtask

  task automatic take_word();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_vec++;
    if (bus.out !== 16'h0 || bus.out_valid !== 1'b0 || bus.s !== 4'd0 ||
        bus.bit_ready !== 1'b0 || bus.parity_err !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset: out=%h ov=%b s=%0d br=%b pe=%b st=%0d, required 0000 0 0 0 0 0",
               bus.out, bus.out_valid, bus.s, bus.bit_ready, bus.parity_err, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    tick();
    bus.bit_valid = 1'b0;
    n_vec++;
    if (bus.s !== 4'd0 || bus.out !== 16'h0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL idle_ignore: s=%0d out=%h st=%0d, required 0 0000 0", bus.s, bus.out, dbg_state);
    end
  endtask

  task automatic test_aaaa();
    logic [15:0] w;
    w = 16'hAAAA;
    pulse_start();
    n_vec++;
    if (bus.bit_ready !== 1'b1 || bus.s !== 4'd0 || dbg_state !== 2'd1) begin
      n_err++;
      $display("FAIL start: br=%b s=%0d st=%0d, required 1 0 1", bus.bit_ready, bus.s, dbg_state);
    end
    send_bits(w, 15);
`ifndef PARITY_CHECK_EN
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL aaaa_early_valid: out_valid=%b, required 0", bus.out_valid);
    end
`endif
    beat(w[15]);
    send_parity(1'b0);
    n_vec++;
    if (bus.out !== 16'hAAAA || bus.out_valid !== 1'b1 || bus.s !== 4'd0 || bus.bit_ready !== 1'b0) begin
      n_err++;
      $display("FAIL aaaa_word: out=%h ov=%b s=%0d br=%b, required aaaa 1 0 0",
               bus.out, bus.out_valid, bus.s, bus.bit_ready);
    end
    n_vec++;
    if (bus.parity_err !== 1'b0) begin
      n_err++;
      $display("FAIL aaaa_parity: parity_err=%b, required 0", bus.parity_err);
    end
    take_word();
    n_vec++;
    if (bus.out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL aaaa_handshake: ov=%b st=%0d, required 0 0", bus.out_valid, dbg_state);
    end
  endtask

  task automatic test_sweep_gaps();
    logic [15:0] w;
    logic [3:0]  exp_s;
    int          bad;
    w   = 16'h5A3C;
    bad = 0;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      exp_s = 4'(i);
      if (bus.s !== exp_s) bad++;
      beat(w[i]);
      exp_s = 4'(i + 1);
      repeat (2) tick();
      if (bus.s !== exp_s) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL sweep_s: %0d select mismatches, required 0", bad);
    end
    send_parity(^w);
    n_vec++;
    if (bus.out !== 16'h5A3C || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL sweep_word: out=%h ov=%b, required 5a3c 1", bus.out, bus.out_valid);
    end
    take_word();
  endtask

  task automatic test_hold_stall();
    logic [15:0] w;
    int          bad;
    w   = 16'hC3A5;
    bad = 0;
    pulse_start();
    send_bits(w, 16);
    send_parity(^w);
    for (int i = 0; i < 10; i++) begin
      bus.bit_valid = i[0];
      bus.bit_in    = ~i[1];
      bus.start     = (i == 4);
      tick();
      if (bus.bit_ready !== 1'b0 || bus.out !== 16'hC3A5 || bus.out_valid !== 1'b1 || dbg_state !== 2'd3) bad++;
    end
    bus.bit_valid = 1'b0;
    bus.start     = 1'b0;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL hold_stall: %0d cycles not holding c3a5 with br=0, required 0", bad);
    end
    take_word();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release: ov=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_abort();
    logic [15:0] w;
    pulse_start();
    send_bits(16'h00FF, 7);
    n_vec++;
    if (bus.s !== 4'd7 || bus.out !== 16'h007F) begin
      n_err++;
      $display("FAIL abort_partial: s=%0d out=%h, required 7 007f", bus.s, bus.out);
    end
    pulse_start();
    n_vec++;
    if (bus.s !== 4'd0 || bus.out !== 16'h0000) begin
      n_err++;
      $display("FAIL abort_clear: s=%0d out=%h, required 0 0000", bus.s, bus.out);
    end
    w = 16'h1234;
    send_bits(w, 16);
    send_parity(^w);
    n_vec++;
    if (bus.out !== 16'h1234 || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL abort_word: out=%h ov=%b, required 1234 1", bus.out, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    w = 16'hBEEF;
    // word 1234 still held: take it and restart in the same cycle, capturing bit 0 of the next word
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    bus.bit_valid = 1'b1;
    bus.bit_in    = w[0];
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.s !== 4'd1 || bus.out !== 16'h0001 || dbg_state !== 2'd1) begin
      n_err++;
      $display("FAIL b2b_restart: ov=%b s=%0d out=%h st=%0d, required 0 1 0001 1",
               bus.out_valid, bus.s, bus.out, dbg_state);
    end
    for (int i = 1; i < 16; i++) beat(w[i]);
    send_parity(^w);
    n_vec++;
    if (bus.out !== 16'hBEEF || bus.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_word: out=%h ov=%b, required beef 1", bus.out, bus.out_valid);
    end
    take_word();
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_bits(16'hFFFF, 9);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.out !== 16'h0 || bus.out_valid !== 1'b0 || bus.s !== 4'd0 || bus.bit_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: out=%h ov=%b s=%0d br=%b, required 0000 0 0 0",
               bus.out, bus.out_valid, bus.s, bus.bit_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_bits(16'hFFFF, 16);
    send_parity(1'b0);
    n_vec++;
    if (bus.out !== 16'hFFFF || bus.out_valid !== 1'b1 || bus.parity_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_fresh: out=%h ov=%b pe=%b, required ffff 1 0", bus.out, bus.out_valid, bus.parity_err);
    end
    take_word();
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    pulse_start();
    send_bits(16'h0001, 16);
    n_vec++;
    if (bus.out_valid !== 1'b0 || dbg_state !== 2'd2 || bus.bit_ready !== 1'b1) begin
      n_err++;
      $display("FAIL parity_state: ov=%b st=%0d br=%b, required 0 2 1", bus.out_valid, dbg_state, bus.bit_ready);
    end
    beat(1'b1);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.parity_err !== 1'b0) begin
      n_err++;
      $display("FAIL parity_good: ov=%b pe=%b, required 1 0", bus.out_valid, bus.parity_err);
    end
    take_word();
    pulse_start();
    send_bits(16'h0001, 16);
    beat(1'b0);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.parity_err !== 1'b1) begin
      n_err++;
      $display("FAIL parity_bad: ov=%b pe=%b, required 1 1", bus.out_valid, bus.parity_err);
    end
    take_word();
    n_vec++;
    if (bus.parity_err !== 1'b0) begin
      n_err++;
      $display("FAIL parity_clear: pe=%b, required 0", bus.parity_err);
    end
  endtask
`endif

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b1;
    bus.start     = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_aaaa();
    test_sweep_gaps();
    test_hold_stall();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
